clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-setting front end for the clock. Debounces three raw push-buttons, runs a hour/minute edit state machine and drives the `load`, `ora_setata` and `min_setat` inputs of the time counter. It sits directly upstream of that counter. It also provides `editing`, which the top level uses to gate the counter's `enable` while the user is editing.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required before a debounced level changes. Simulation value is 16; board builds override it, for example 500000.
- `TIMEOUT_CYCLES`, default 1024: number of cycles without a button press in an edit state before the edit is abandoned.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `btn_mode`  in  1  raw asynchronous button, 1 = pressed
- `btn_inc`  in  1  raw asynchronous button
- `btn_dec`  in  1  raw asynchronous button
- `cur_ora`  in  5  current hour from the counter, 0..23
- `cur_minut`  in  6  current minute from the counter, 0..59
- `load`  out  1  one-cycle commit strobe to the counter
- `ora_setata`  out  5  edited hour, valid while `load`=1
- `min_setat`  out  6  edited minute, valid while `load`=1
- `editing`  out  1  high in SET_H and SET_M
- `sel_ora`  out  1  high in SET_H (drives display blink)
- `sel_min`  out  1  high in SET_M

## Operation

- Button path, identical for each button:
  - 2-FF synchronizer.
  - Stability counter: it resets whenever the synchronized sample equals the debounced level. When it reaches `DEBOUNCE_CYCLES`, the debounced level takes the sample value.
  - A press pulse is asserted for exactly 1 cycle on each 0→1 transition of the debounced level.
  - Releases generate no pulse.
- States: RUN, SET_H, SET_M, COMMIT. Reset state is RUN.
- RUN:
  - A mode press goes to SET_H and copies `cur_ora`/`cur_minut` into the edit registers.
  - Inc and dec presses are ignored.
- SET_H:
  - Inc: hour+1, wrapping 23→0.
  - Dec: hour−1, wrapping 0→23.
  - Mode: go to SET_M.
- SET_M:
  - Inc: minute+1, wrapping 59→0.
  - Dec: minute−1, wrapping 0→59.
  - Mode: go to COMMIT.
- COMMIT: `load`=1 for this single cycle, then RUN unconditionally.
- Simultaneous presses:
  - Mode together with inc or dec: mode wins and the other press is discarded.
  - Inc together with dec in the same cycle: both are ignored and there is no change.
- Timeout:
  - A timeout counter runs in SET_H and SET_M and clears on any press pulse.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to RUN with no `load`, and the edit is discarded.
- Edit registers never hold out-of-range values. The arithmetic is explicit compare-and-wrap, not modulo on the bit width.
- `ora_setata`/`min_setat` continuously show the edit registers. The counter samples them only when `load`=1.
- Reset mid-edit: the FSM goes to RUN, edit registers and debouncers clear, and no `load` is issued.

## Timing

- Reset values:
  - `load`=0, `ora_setata`=0, `min_setat`=0, `editing`=0, `sel_ora`=0, `sel_min`=0.
  - Debounced levels are 0 and all counters are 0.
- If a raw button rises at cycle t and stays stable, its press pulse is high at cycle t+2+`DEBOUNCE_CYCLES`+1, for one cycle.
- A press pulse at cycle p causes the following to take effect at p+1:
  - the state change;
  - the edit register update;
  - the changes on `editing`/`sel_*`.
- Mode press in SET_M at cycle p: COMMIT and `load`=1 at cycle p+1; RUN at cycle p+2.
- The counter must apply `load` in the same cycle, p+1. `editing` is already 0 in COMMIT, so counting resumes from the loaded time.
- The press that exits RUN is not also counted as an edit.

## Structure

- Package `clock_pkg` holds:
  - `HOUR_MAX`=23, `MIN_MAX`=59;
  - `HOUR_W`=5, `MIN_W`=6;
  - the state enum `set_state_t` {RUN, SET_H, SET_M, COMMIT}.
  - The counter imports the same constants.
- Sub-module `btn_debounce` contains the synchronizer, stability counter and press pulse, parameterized by `DEBOUNCE_CYCLES`. It is instantiated three times.
- The top-level FSM, edit registers and timeout counter are in `clock_set_ctrl`.

## Test plan

- Debounce: glitch `btn_inc` high for `DEBOUNCE_CYCLES`−1 cycles in SET_H → no pulse and hour unchanged. Hold it for 40 cycles → exactly one pulse and hour +1.
- Full set: `cur_ora`=10, `cur_minut`=30. Sequence mode, inc×3, mode, dec×2, mode → a single `load` cycle with `ora_setata`=13, `min_setat`=28, then RUN with `editing`=0.
- Wrap: start at 23:59. In SET_H press inc → 0. In SET_M press inc → 0. Dec from 0 gives 23 for hours and 59 for minutes.
- Simultaneous events:
  - mode+inc in the same cycle in SET_H → SET_M with hour unchanged;
  - inc+dec in the same cycle → no change.
- Timeout: enter SET_H, press inc once, then idle `TIMEOUT_CYCLES` cycles → RUN with `load` never asserted.
- Reset mid-edit: assert `rst` in SET_M → all outputs 0 next cycle, RUN, and a following mode press restarts at SET_H with the current time.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared clock constants, edit-FSM state type and wrap-around step helpers.
// Pure declarations: no latency.
// No flow control.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } set_state_t;

  // Step an hour by one, wrapping explicitly at 0 and HOUR_MAX.
  function automatic logic [HOUR_W-1:0] hour_step(input logic [HOUR_W-1:0] h,
                                                  input logic up);
    if (up) return (h >= HOUR_MAX) ? '0 : h + HOUR_W'(1);
    else    return (h == '0 || h > HOUR_MAX) ? HOUR_MAX : h - HOUR_W'(1);
  endfunction

  // Step a minute by one, wrapping explicitly at 0 and MIN_MAX.
  function automatic logic [MIN_W-1:0] min_step(input logic [MIN_W-1:0] m,
                                                input logic up);
    if (up) return (m >= MIN_MAX) ? '0 : m + MIN_W'(1);
    else    return (m == '0 || m > MIN_MAX) ? MIN_MAX : m - MIN_W'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF sync -> stability counter -> one-cycle press pulse.
// Latency: press pulse DEBOUNCE_CYCLES+3 cycles after a clean raw rise.
// No backpressure; releases are filtered the same way but never pulse.
module btn_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Synchronize, count consecutive disagreeing samples, flip level and pulse on rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting front end: debounced buttons drive an hour/minute edit FSM.
// Latency: FSM, edit registers and flags update the cycle after a press pulse.
// No backpressure; o_load is a single-cycle strobe the counter must take as-is.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_btn_mode,
  input  logic              i_btn_inc,
  input  logic              i_btn_dec,
  input  logic [HOUR_W-1:0] i_cur_ora,
  input  logic [MIN_W-1:0]  i_cur_minut,
  output logic              o_load,
  output logic [HOUR_W-1:0] o_ora_setata,
  output logic [MIN_W-1:0]  o_min_setat,
  output logic              o_editing,
  output logic              o_sel_ora,
  output logic              o_sel_min
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic w_mode;
  logic w_inc;
  logic w_dec;
  logic w_any;
  logic w_step;
  logic w_up;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .i_btn(i_btn_mode), .o_press(w_mode)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .rst(rst), .i_btn(i_btn_inc), .o_press(w_inc)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk(clk), .rst(rst), .i_btn(i_btn_dec), .o_press(w_dec)
  );

  // Mode overrides inc/dec; inc and dec together cancel out.
  assign w_any  = w_mode | w_inc | w_dec;
  assign w_step = ~w_mode & (w_inc ^ w_dec);
  assign w_up   = w_inc;

  set_state_t        r_state;
  logic [HOUR_W-1:0] r_hour;
  logic [MIN_W-1:0]  r_min;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_load;
  logic              r_editing;
  logic              r_sel_ora;
  logic              r_sel_min;

  // Edit FSM with edit registers, inactivity timeout and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_hour    <= '0;
      r_min     <= '0;
      r_to_cnt  <= '0;
      r_load    <= 1'b0;
      r_editing <= 1'b0;
      r_sel_ora <= 1'b0;
      r_sel_min <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        RUN: begin
          r_to_cnt <= '0;
          if (w_mode) begin
            r_state   <= SET_H;
            // Clamp keeps the edit registers in range even for a bad counter value.
            r_hour    <= (i_cur_ora > HOUR_MAX) ? HOUR_MAX : i_cur_ora;
            r_min     <= (i_cur_minut > MIN_MAX) ? MIN_MAX : i_cur_minut;
            r_editing <= 1'b1;
            r_sel_ora <= 1'b1;
          end
        end
        SET_H: begin
          if (w_any) begin
            r_to_cnt <= '0;
            if (w_mode) begin
              r_state   <= SET_M;
              r_sel_ora <= 1'b0;
              r_sel_min <= 1'b1;
            end else if (w_step) begin
              r_hour <= hour_step(r_hour, w_up);
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_state   <= RUN;
            r_to_cnt  <= '0;
            r_editing <= 1'b0;
            r_sel_ora <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        SET_M: begin
          if (w_any) begin
            r_to_cnt <= '0;
            if (w_mode) begin
              r_state   <= COMMIT;
              r_load    <= 1'b1;
              r_editing <= 1'b0;
              r_sel_min <= 1'b0;
            end else if (w_step) begin
              r_min <= min_step(r_min, w_up);
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_state   <= RUN;
            r_to_cnt  <= '0;
            r_editing <= 1'b0;
            r_sel_min <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        COMMIT: begin
          r_state  <= RUN;
          r_to_cnt <= '0;
        end
        default: begin
          r_state   <= RUN;
          r_editing <= 1'b0;
          r_sel_ora <= 1'b0;
          r_sel_min <= 1'b0;
        end
      endcase
    end
  end

  assign o_load       = r_load;
  assign o_ora_setata = r_hour;
  assign o_min_setat  = r_min;
  assign o_editing    = r_editing;
  assign o_sel_ora    = r_sel_ora;
  assign o_sel_min    = r_sel_min;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: vector table of button presses plus
// hand-written debounce, timing, timeout and reset sequences.
module tb_clock_set_ctrl;

  localparam int DB = 16;
  localparam int TO = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [4:0] cur_ora = 5'd0;
  logic [5:0] cur_minut = 6'd0;
  logic       load;
  logic [4:0] ora_setata;
  logic [5:0] min_setat;
  logic       editing;
  logic       sel_ora;
  logic       sel_min;

  always #5 clk = ~clk;

  clock_set_ctrl #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_btn_mode(btn_mode), .i_btn_inc(btn_inc), .i_btn_dec(btn_dec),
    .i_cur_ora(cur_ora), .i_cur_minut(cur_minut),
    .o_load(load), .o_ora_setata(ora_setata), .o_min_setat(min_setat),
    .o_editing(editing), .o_sel_ora(sel_ora), .o_sel_min(sel_min)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Load monitor: counts strobes, records committed time, checks strobe shape.
  int         load_cnt = 0;
  logic       ld_prev = 1'b0;
  logic [4:0] ld_h[4];
  logic [5:0] ld_m[4];

  always @(negedge clk) begin
    if (!rst && load) begin
      check("load_editing_low", {31'd0, editing}, 0);
      check("load_one_cycle", {31'd0, ld_prev}, 0);
      if (load_cnt < 4) begin
        ld_h[load_cnt] = ora_setata;
        ld_m[load_cnt] = min_setat;
      end
      load_cnt++;
    end
    ld_prev = load;
  end

  typedef struct {
    logic       m, i, d;
    logic [4:0] cur_h;
    logic [5:0] cur_m;
    logic [4:0] exp_h;
    logic [5:0] exp_m;
    logic       exp_ed, exp_sh, exp_sm;
  } vec_t;

  function automatic vec_t mk(int m, int i, int d, int ch, int cm,
                              int eh, int em, int ed, int sh, int sm);
    vec_t v;
    v.m = m[0]; v.i = i[0]; v.d = d[0];
    v.cur_h = ch[4:0]; v.cur_m = cm[5:0];
    v.exp_h = eh[4:0]; v.exp_m = em[5:0];
    v.exp_ed = ed[0]; v.exp_sh = sh[0]; v.exp_sm = sm[0];
    return v;
  endfunction

  // Hold the given buttons long enough to debounce, then release and settle.
  task automatic press(input logic m, input logic i, input logic d);
    @(posedge clk); #1;
    btn_mode = m; btn_inc = i; btn_dec = d;
    repeat (30) @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int eh, input int em,
                            input int ed, input int sh, input int sm);
    check({tag, ".hour"},    ora_setata, eh);
    check({tag, ".min"},     min_setat, em);
    check({tag, ".editing"}, editing, ed);
    check({tag, ".sel_ora"}, sel_ora, sh);
    check({tag, ".sel_min"}, sel_min, sm);
  endtask

  vec_t vecs[18];

  initial begin
    vecs[0]  = mk(0,1,0, 10,30,  0, 0, 0,0,0);  // inc ignored in RUN
    vecs[1]  = mk(1,0,0, 10,30, 10,30, 1,1,0);  // enter SET_H, copy time
    vecs[2]  = mk(0,1,0, 10,30, 11,30, 1,1,0);
    vecs[3]  = mk(0,1,0, 10,30, 12,30, 1,1,0);
    vecs[4]  = mk(0,1,0, 10,30, 13,30, 1,1,0);
    vecs[5]  = mk(1,0,0, 10,30, 13,30, 1,0,1);  // to SET_M
    vecs[6]  = mk(0,0,1, 10,30, 13,29, 1,0,1);
    vecs[7]  = mk(0,0,1, 10,30, 13,28, 1,0,1);
    vecs[8]  = mk(1,0,0, 10,30, 13,28, 0,0,0);  // commit, back to RUN
    vecs[9]  = mk(1,0,0, 23,59, 23,59, 1,1,0);
    vecs[10] = mk(0,1,0, 23,59,  0,59, 1,1,0);  // 23 -> 0
    vecs[11] = mk(0,0,1, 23,59, 23,59, 1,1,0);  // 0 -> 23
    vecs[12] = mk(0,1,1, 23,59, 23,59, 1,1,0);  // inc+dec cancel
    vecs[13] = mk(1,1,0, 23,59, 23,59, 1,0,1);  // mode wins over inc
    vecs[14] = mk(0,1,0, 23,59, 23, 0, 1,0,1);  // 59 -> 0
    vecs[15] = mk(0,0,1, 23,59, 23,59, 1,0,1);  // 0 -> 59
    vecs[16] = mk(0,1,1, 23,59, 23,59, 1,0,1);  // inc+dec cancel
    vecs[17] = mk(1,0,0, 23,59, 23,59, 0,0,0);  // commit 23:59

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
    check("reset.load", load, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Vector table
    for (int k = 0; k < 18; k++) begin
      cur_ora = vecs[k].cur_h;
      cur_minut = vecs[k].cur_m;
      press(vecs[k].m, vecs[k].i, vecs[k].d);
      check_outs($sformatf("vec%0d", k), vecs[k].exp_h, vecs[k].exp_m,
                 vecs[k].exp_ed, vecs[k].exp_sh, vecs[k].exp_sm);
    end
    check("table.load_cnt", load_cnt, 2);
    check("table.load0_h", ld_h[0], 13);
    check("table.load0_m", ld_m[0], 28);
    check("table.load1_h", ld_h[1], 23);
    check("table.load1_m", ld_m[1], 59);

    // Debounce: a short glitch is filtered, a long hold counts once
    cur_ora = 5'd5; cur_minut = 6'd7;
    press(1'b1, 1'b0, 1'b0);
    check("glitch.enter_hour", ora_setata, 5);
    @(posedge clk); #1;
    btn_inc = 1'b1;
    repeat (DB - 1) @(posedge clk);
    #1;
    btn_inc = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("glitch.hour_unchanged", ora_setata, 5);
    btn_inc = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    btn_inc = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("hold.hour_plus_one", ora_setata, 6);

    // Exact latency: raw rise -> edit register update DB+4 edges later
    @(posedge clk); #1;
    btn_inc = 1'b1;
    repeat (DB + 3) @(posedge clk);
    #1;
    check("latency.before", ora_setata, 6);
    @(posedge clk); #1;
    check("latency.at", ora_setata, 7);
    btn_inc = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    // Commit timing: load for exactly one cycle, then RUN
    press(1'b1, 1'b0, 1'b0);
    check("commit.in_set_m", sel_min, 1);
    btn_mode = 1'b1;
    repeat (DB + 3) @(posedge clk);
    #1;
    check("commit.load_before", load, 0);
    check("commit.editing_before", editing, 1);
    @(posedge clk); #1;
    check("commit.load_at", load, 1);
    check("commit.editing_at", editing, 0);
    check("commit.hour_at", ora_setata, 7);
    check("commit.min_at", min_setat, 7);
    @(posedge clk); #1;
    check("commit.load_after", load, 0);
    check("commit.sel_min_after", sel_min, 0);
    btn_mode = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("commit.load_cnt", load_cnt, 3);

    // Timeout: idle in SET_H abandons the edit without load
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check("timeout.hour", ora_setata, 6);
    repeat (TO - 100) @(posedge clk);
    #1;
    check("timeout.still_editing", editing, 1);
    repeat (200) @(posedge clk);
    #1;
    check("timeout.editing", editing, 0);
    check("timeout.sel_ora", sel_ora, 0);
    check("timeout.load_cnt", load_cnt, 3);

    // Reset mid-edit in SET_M
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("rstmid.in_set_m", sel_min, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_outs("rstmid", 0, 0, 0, 0, 0);
    check("rstmid.load", load, 0);
    rst = 1'b0;
    cur_ora = 5'd8; cur_minut = 6'd9;
    press(1'b1, 1'b0, 1'b0);
    check_outs("rstmid.restart", 8, 9, 1, 1, 0);
    check("rstmid.load_cnt", load_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
